pipe_regfile: RTL and testbench

PIPE_REGFILE -- requirements
Module: pipe_regfile

---
 rtl/pipe_regfile_pkg.sv | 42 ++++
 rtl/regfile_scoreboard.sv | 105 ++++++++++
 rtl/pipe_regfile.sv | 93 +++++++++
 tb/tb_pipe_regfile.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_regfile_pkg.sv
// ---------------------------------------------------------------------------
// pipe_regfile_pkg
//   Shared CPU datapath package. Holds the default register-file geometry
//   and the busy-bit update encoding used by the regfile scoreboard.
//   Contents:
//     CPU_DATA_W, CPU_ADDR_W, CPU_NRD : default data width, address width
//                                       and read-port count
//     busy_op_e                       : per-register busy-bit action
//     busy_op_sel()                   : resolves flush/reserve/writeback
//                                       priority into one busy_op_e
// ---------------------------------------------------------------------------
package pipe_regfile_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_ADDR_W = 5;
  localparam int CPU_NRD    = 2;

  typedef enum logic [1:0] {
    BUSY_HOLD  = 2'd0,
    BUSY_SET   = 2'd1,
    BUSY_CLEAR = 2'd2
  } busy_op_e;

  // Priority: flush clears everything; a new reservation beats a
  // writeback to the same register (the newer producer owns it).
  function automatic busy_op_e busy_op_sel(input logic flush_hit,
                                           input logic set_hit,
                                           input logic clr_hit);
    busy_op_e op;
    if (flush_hit) begin
      op = BUSY_CLEAR;
    end else if (set_hit) begin
      op = BUSY_SET;
    end else if (clr_hit) begin
      op = BUSY_CLEAR;
    end else begin
      op = BUSY_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//   One busy bit per architectural register plus a registered count of
//   busy registers. Register 0 is never reserved.
//   Ports:
//     clk, rst          : clock, asynchronous active-high reset
//     rd_addr           : NRD packed read addresses
//     rd_busy           : per-port busy, masked by a same-cycle writeback
//     wr_en, wr_addr    : writeback (clears busy)
//     rsv_en, rsv_addr  : reservation at issue (sets busy)
//     flush             : drop every reservation
//     pend_cnt          : number of registers currently busy
// ---------------------------------------------------------------------------
module regfile_scoreboard
  import pipe_regfile_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int NRD    = CPU_NRD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  input  logic                  flush,
  output logic [ADDR_W:0]       pend_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};

  logic [DEPTH-1:0] busy_r;
  logic [DEPTH-1:0] busy_nxt_s;
  logic [ADDR_W:0]  cnt_r;
  logic [ADDR_W:0]  cnt_nxt_s;
  logic             set_s;
  logic             clr_s;
  logic             inc_s;
  logic             dec_s;

  // Qualify reservation/writeback and work out the count delta.
  always_comb begin
    set_s = rsv_en && (rsv_addr != ADDR_ZERO) && !flush;
    clr_s = wr_en && (wr_addr != ADDR_ZERO);
    // Only a transition of a busy bit moves the counter. A writeback to
    // the register being re-reserved in the same cycle leaves it busy.
    inc_s = set_s && !busy_r[rsv_addr];
    dec_s = clr_s && busy_r[wr_addr] && !(set_s && (rsv_addr == wr_addr));
  end

  // Next-state for every busy bit.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int i = 0; i < DEPTH; i++) begin
      case (busy_op_sel(flush,
                        set_s && (rsv_addr == ADDR_W'(i)),
                        clr_s && (wr_addr  == ADDR_W'(i))))
        BUSY_SET:   busy_nxt_s[i] = 1'b1;
        BUSY_CLEAR: busy_nxt_s[i] = 1'b0;
        BUSY_HOLD:  busy_nxt_s[i] = busy_r[i];
        default:    busy_nxt_s[i] = busy_r[i];
      endcase
    end
  end

  // Next-state for the pending counter (tracks popcount of busy_r).
  always_comb begin
    if (flush) begin
      cnt_nxt_s = CNT_ZERO;
    end else begin
      case ({inc_s, dec_s})
        2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
        2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
        default: cnt_nxt_s = cnt_r;
      endcase
    end
  end

  // Busy bits and counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= {DEPTH{1'b0}};
      cnt_r  <= CNT_ZERO;
    end else begin
      busy_r <= busy_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

  assign pend_cnt = cnt_r;

  // Per-port busy lookup; a writeback landing this cycle hides the busy
  // bit because its data is already visible through the bypass.
  for (genvar k = 0; k < NRD; k++) begin : g_busy
    logic [ADDR_W-1:0] ra_s;
    assign ra_s       = rd_addr[k*ADDR_W +: ADDR_W];
    assign rd_busy[k] = busy_r[ra_s] && !(wr_en && (wr_addr == ra_s));
  end

endmodule

// File: rtl/pipe_regfile.sv
// ---------------------------------------------------------------------------
// pipe_regfile
//   Pipelined-CPU register file: 2**ADDR_W x DATA_W data array with
//   combinational, write-through-bypassed read ports, plus a reservation
//   scoreboard for in-flight producers.
//   Ports:
//     clk, rst          : clock, asynchronous active-high reset
//     rd_addr / rd_data : NRD packed read addresses / read data
//     rd_busy           : per-port outstanding-reservation flag
//     wr_en/addr/data   : writeback
//     rsv_en/rsv_addr   : destination reservation at issue
//     flush             : drop all reservations
//     pend_cnt          : number of reserved registers
//   Register 0 reads as zero, is never written and never reserved.
// ---------------------------------------------------------------------------
module pipe_regfile
  import pipe_regfile_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int NRD    = CPU_NRD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  input  logic                  flush,
  output logic [ADDR_W:0]       pend_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              wr_ok_s;

  assign wr_ok_s = wr_en && (wr_addr != ADDR_ZERO);

  // Data array; reset clears every entry, r0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= DATA_ZERO;
      end
    end else if (wr_ok_s) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra_s;
    logic [DATA_W-1:0] rd_s;

    assign ra_s = rd_addr[k*ADDR_W +: ADDR_W];

    // Read mux: bypass a same-cycle writeback, force r0 to zero.
    always_comb begin
      if (wr_ok_s && (wr_addr == ra_s)) begin
        rd_s = wr_data;
      end else if (ra_s == ADDR_ZERO) begin
        rd_s = DATA_ZERO;
      end else begin
        rd_s = mem_r[ra_s];
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = rd_s;
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NRD    (NRD)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush),
    .pend_cnt (pend_cnt)
  );

endmodule

// File: tb/tb_pipe_regfile.sv
// ---------------------------------------------------------------------------
// tb_pipe_regfile
//   Directed self-checking bench for pipe_regfile with default geometry
//   (32-bit data, 32 registers, 2 read ports). Inputs change 1 time unit
//   after the rising edge; outputs are sampled mid-cycle.
// ---------------------------------------------------------------------------
module tb_pipe_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic             flush;
  logic [AW:0]      pend_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_regfile #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NRD    (NR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush),
    .pend_cnt (pend_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    rsv_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    rst      = 1'b1;
    idle();
    wr_addr  = 5'd0;
    wr_data  = 32'h0;
    rsv_addr = 5'd0;
    rd(5'd5, 5'd5);
    #2;
    chk("reset_pend", 64'(pend_cnt), 64'd0);
    chk("reset_busy", 64'(rd_busy), 64'd0);
    chk("reset_data", rd_data, 64'h0);
    // Bypass is still visible while in reset.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000_1111;
    #1;
    chk("reset_bypass", rd_data, {32'h0000_1111, 32'h0000_1111});
    tick();
    idle();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_write_ignored", rd_data, 64'h0);

    // Write r5, read back on both ports.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    tick();
    idle(); rd(5'd5, 5'd5);
    #1;
    chk("r5_both_ports", rd_data, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
    chk("r5_pend", 64'(pend_cnt), 64'd0);

    // r0 is never written and never bypassed.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_1234; rd(5'd0, 5'd0);
    #1;
    chk("r0_no_bypass", rd_data, 64'h0);
    tick();
    idle();
    #1;
    chk("r0_reads_zero", rd_data, 64'h0);

    // Same-cycle write-through bypass on port 0 only.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5; rd(5'd7, 5'd5);
    #1;
    chk("bypass_r7", rd_data, {32'hDEAD_BEEF, 32'hA5A5_A5A5});
    tick();
    idle(); rd(5'd7, 5'd7);
    #1;
    chk("r7_stored", rd_data, {32'hA5A5_A5A5, 32'hA5A5_A5A5});

    // Reserve r3, r4.
    rsv_en = 1'b1; rsv_addr = 5'd3;
    tick();
    rsv_addr = 5'd4;
    tick();
    idle(); rd(5'd3, 5'd4);
    #1;
    chk("rsv_pend2", 64'(pend_cnt), 64'd2);
    chk("rsv_busy34", 64'(rd_busy), 64'b11);
    // Writeback r3 masks its busy in the same cycle.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0033;
    #1;
    chk("wb_mask_busy", 64'(rd_busy), 64'b10);
    chk("wb_bypass_r3", 64'(rd_data[31:0]), 64'h33);
    tick();
    idle();
    #1;
    chk("wb_pend1", 64'(pend_cnt), 64'd1);
    chk("wb_busy_after", 64'(rd_busy), 64'b10);

    // Re-reserving a busy register leaves the count alone.
    rsv_en = 1'b1; rsv_addr = 5'd4;
    tick();
    idle();
    #1;
    chk("rerserve_pend", 64'(pend_cnt), 64'd1);
    chk("rerserve_busy", 64'(rd_busy), 64'b10);

    // Reserve and write r9 together, r9 not busy before: +1.
    rsv_en = 1'b1; rsv_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
    rd(5'd9, 5'd0);
    #1;
    chk("rsvwr_busy_masked", 64'(rd_busy), 64'b00);
    chk("rsvwr_bypass", 64'(rd_data[31:0]), 64'h55);
    tick();
    idle();
    #1;
    chk("rsvwr_pend", 64'(pend_cnt), 64'd2);
    chk("rsvwr_busy", 64'(rd_busy), 64'b01);
    chk("rsvwr_data", 64'(rd_data[31:0]), 64'h55);
    // Again with r9 already busy: +0.
    rsv_en = 1'b1; rsv_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h66;
    tick();
    idle();
    #1;
    chk("rsvwr2_pend", 64'(pend_cnt), 64'd2);
    chk("rsvwr2_busy", 64'(rd_busy), 64'b01);
    chk("rsvwr2_data", 64'(rd_data[31:0]), 64'h66);

    // Write to a non-busy register: count unchanged.
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h10;
    tick();
    idle(); rd(5'd10, 5'd9);
    #1;
    chk("wr_nonbusy_pend", 64'(pend_cnt), 64'd2);
    chk("wr_nonbusy_data", 64'(rd_data[31:0]), 64'h10);

    // Reserve r0..r31 (r0 ignored, r4/r9 already busy) -> 31.
    for (int i = 0; i < 32; i++) begin
      rsv_en = 1'b1; rsv_addr = AW'(i);
      tick();
    end
    idle(); rd(5'd0, 5'd31);
    #1;
    chk("all_rsv_pend", 64'(pend_cnt), 64'd31);
    chk("all_rsv_busy_r0", 64'(rd_busy), 64'b10);

    // Flush with same-cycle write (kept) and reserve (ignored).
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd12;
    wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'hBB;
    tick();
    idle(); rd(5'd12, 5'd11);
    #1;
    chk("flush_pend", 64'(pend_cnt), 64'd0);
    chk("flush_busy", 64'(rd_busy), 64'b00);
    chk("flush_write", rd_data, {32'h0000_00BB, 32'h0});
    rd(5'd5, 5'd7);
    #1;
    chk("flush_data_kept", rd_data, {32'hA5A5_A5A5, 32'hDEAD_BEEF});

    // Reserve r2, write r2 while reserving r6, then reset mid-cycle.
    rsv_en = 1'b1; rsv_addr = 5'd2;
    tick();
    rsv_addr = 5'd6; wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h77;
    tick();
    idle(); rd(5'd2, 5'd6);
    #1;
    chk("pre_rst_pend", 64'(pend_cnt), 64'd1);
    chk("pre_rst_data", 64'(rd_data[31:0]), 64'h77);
    chk("pre_rst_busy", 64'(rd_busy), 64'b10);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_data", rd_data, 64'h0);
    chk("midrst_pend", 64'(pend_cnt), 64'd0);
    chk("midrst_busy", 64'(rd_busy), 64'b00);
    tick();
    rst = 1'b0;
    rd(5'd5, 5'd5);
    #1;
    chk("post_rst_r5", rd_data, 64'h0);
    rsv_en = 1'b1; rsv_addr = 5'd2;
    tick();
    idle(); rd(5'd2, 5'd0);
    #1;
    chk("post_rst_pend", 64'(pend_cnt), 64'd1);
    chk("post_rst_busy", 64'(rd_busy), 64'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
